// File: rtl/fft_pair_buffer_pkg.sv
// fft_pair_buffer_pkg: shared FFT sample width, complex sample type and stage depth helper
package fft_pair_buffer_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_LOG_N = 4;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] re;
    logic [DEF_WIDTH-1:0] im;
  } cplx_t;
  function automatic int stage_log_depth(input int log_n, input int stage);
    return log_n - 1 - stage;
  endfunction
  localparam int DEF_LOG_DEPTH = stage_log_depth(DEF_LOG_N, 0);
endpackage

// File: rtl/fft_delay_ram.sv
// fft_delay_ram: single-port synchronous-read delay memory, DEPTH x 2*WIDTH
module fft_delay_ram
  import fft_pair_buffer_pkg::*;
#(
  parameter int AW = DEF_LOG_DEPTH,
  parameter int DW = 2 * DEF_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // write port; contents are deliberately left unreset
  always_ff @(posedge clock) if (en && we) mem[addr] <= wdata;
  // registered read that holds between reads and clears on reset
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
endmodule

// File: rtl/fft_pair_buffer.sv
// fft_pair_buffer: pairs x[k] with x[k+DEPTH] for the radix-2 DIF butterfly
module fft_pair_buffer
  import fft_pair_buffer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sync,
  input  logic                 di_en,
  input  logic [WIDTH-1:0]     di_re,
  input  logic [WIDTH-1:0]     di_im,
  output logic                 out_en,
  output logic [WIDTH-1:0]     a_re,
  output logic [WIDTH-1:0]     a_im,
  output logic [WIDTH-1:0]     b_re,
  output logic [WIDTH-1:0]     b_im,
  output logic [LOG_DEPTH-1:0] out_idx,
  output logic                 half
);
  logic [LOG_DEPTH:0]   cnt;
  logic [LOG_DEPTH-1:0] addr;
  logic [2*WIDTH-1:0]   rdata;
  logic                 acc;
  logic                 rd;
  assign half = cnt[LOG_DEPTH];
  assign addr = cnt[LOG_DEPTH-1:0];
  assign acc  = di_en && !sync;
  assign rd   = acc && half;
  assign a_re = rdata[2*WIDTH-1:WIDTH];
  assign a_im = rdata[WIDTH-1:0];
  fft_delay_ram #(.AW(LOG_DEPTH), .DW(2*WIDTH)) u_ram (
    .clock(clock),
    .reset(reset),
    .en(acc),
    .we(!half),
    .addr(addr),
    .wdata({di_re, di_im}),
    .rdata(rdata)
  );
  // position counter, pair strobe and captured second-half sample
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt     <= '0;
      out_en  <= 1'b0;
      b_re    <= '0;
      b_im    <= '0;
      out_idx <= '0;
    end else begin
      cnt    <= sync ? '0 : acc ? cnt + 1'b1 : cnt;
      out_en <= rd;
      if (rd) begin
        b_re    <= di_re;
        b_im    <= di_im;
        out_idx <= addr;
      end
    end
endmodule

// File: tb/tb_fft_pair_buffer.sv
// tb_fft_pair_buffer: scoreboard bench for the butterfly pair buffer
module tb_fft_pair_buffer;
  localparam int W  = 16;
  localparam int LD = 2;
  localparam int D  = 1 << LD;
  typedef struct {
    logic [W-1:0]  ar, ai, br, bi;
    logic [LD-1:0] idx;
    int            due;
    bit            bf;
  } exp_t;
  logic clock = 0, reset = 1, sync = 0, di_en = 0;
  logic [W-1:0] di_re = 0, di_im = 0;
  logic out_en, half;
  logic [W-1:0] a_re, a_im, b_re, b_im;
  logic [LD-1:0] out_idx;
  exp_t q[$];
  logic [W-1:0] mre [D];
  logic [W-1:0] mim [D];
  logic [LD:0] mpos = 0;
  int cyc = 0, checks = 0, passes = 0;
  bit bf_mode = 0;
  fft_pair_buffer #(.WIDTH(W), .LOG_DEPTH(LD)) dut (
    .clock(clock), .reset(reset), .sync(sync), .di_en(di_en),
    .di_re(di_re), .di_im(di_im), .out_en(out_en),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_idx(out_idx), .half(half)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
  endtask
  task automatic drive(input bit en, input bit sy, input logic [W-1:0] re, input logic [W-1:0] im);
    exp_t e;
    di_en = en; sync = sy; di_re = re; di_im = im;
    check("half", {31'd0, half}, {31'd0, mpos[LD]});
    if (sy) mpos = 0;
    else if (en) begin
      if (!mpos[LD]) begin
        mre[mpos[LD-1:0]] = re;
        mim[mpos[LD-1:0]] = im;
      end else begin
        e.ar = mre[mpos[LD-1:0]]; e.ai = mim[mpos[LD-1:0]];
        e.br = re; e.bi = im; e.idx = mpos[LD-1:0];
        e.due = cyc + 1; e.bf = bf_mode && mpos[LD-1:0] == 0;
        q.push_back(e);
      end
      mpos = mpos + 1'b1;
    end
    @(posedge clock); #1;
  endtask
  always @(negedge clock) if (out_en) begin
    exp_t e;
    if (q.size() == 0) check("unexpected_pulse", {29'd0, out_idx, out_en}, 32'd0);
    else begin
      e = q.pop_front();
      check("pulse_cycle", cyc, e.due);
      check("a_re", {16'd0, a_re}, {16'd0, e.ar});
      check("a_im", {16'd0, a_im}, {16'd0, e.ai});
      check("b_re", {16'd0, b_re}, {16'd0, e.br});
      check("b_im", {16'd0, b_im}, {16'd0, e.bi});
      check("out_idx", {30'd0, out_idx}, {30'd0, e.idx});
      if (e.bf) begin
        logic [W-1:0] cr, ci, dr, dI;
        cr = a_re + b_re; ci = a_im + b_im; dr = a_re - b_re; dI = a_im - b_im;
        check("bf_c_re", {16'd0, cr}, 32'd4);
        check("bf_c_im", {16'd0, ci}, 32'd2);
        check("bf_d_re", {16'd0, dr}, 32'd2);
        check("bf_d_im", {16'd0, dI}, 32'd6);
      end
    end
  end
  initial begin
    #3;
    check("rst_out_en", {31'd0, out_en}, 32'd0);
    check("rst_half", {31'd0, half}, 32'd0);
    check("rst_ab", {a_re, b_re}, 32'd0);
    check("rst_idx", {30'd0, out_idx}, 32'd0);
    @(posedge clock); #1 reset = 0;
    for (int i = 1; i <= 8; i++) drive(1, 0, 16'(i), 16'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 16'(i), 16'd0);
      drive(0, 0, 16'hdead, 16'hbeef);
    end
    for (int i = 1; i <= 8; i++) drive(1, 0, 16'(i), 16'(-i));
    for (int i = 11; i <= 18; i++) drive(1, 0, 16'(i), 16'(-i));
    for (int i = 1; i <= 6; i++) drive(1, 0, 16'(i), 16'd0);
    drive(1, 1, 16'd99, 16'd99);
    for (int i = 21; i <= 28; i++) drive(1, 0, 16'(i), 16'd0);
    for (int i = 1; i <= 5; i++) drive(1, 0, 16'(i), 16'd0);
    di_en = 0;
    @(negedge clock); #2;
    reset = 1;
    #1;
    check("mid_rst_out_en", {31'd0, out_en}, 32'd0);
    check("mid_rst_a", {a_re, a_im}, 32'd0);
    check("mid_rst_b", {b_re, b_im}, 32'd0);
    check("mid_rst_idx", {30'd0, out_idx}, 32'd0);
    check("mid_rst_half", {31'd0, half}, 32'd0);
    @(posedge clock); #1 reset = 0;
    mpos = 0;
    for (int i = 1; i <= 8; i++) drive(1, 0, 16'(i), 16'd0);
    bf_mode = 1;
    drive(1, 0, 16'd3, 16'd4);
    for (int i = 0; i < 3; i++) drive(1, 0, 16'd0, 16'd0);
    drive(1, 0, 16'd1, 16'hfffe);
    for (int i = 0; i < 3; i++) drive(1, 0, 16'd0, 16'd0);
    bf_mode = 0;
    for (int i = 0; i < 3; i++) drive(0, 0, 16'd0, 16'd0);
    check("drain_pending", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
